uart_receiver_cfg: RTL
======================

UART_RECEIVER_CFG -- requirements
Module: uart_receiver_cfg

Interface
REQ-001 Parameter DIVISOR, 651, sysclk cycles per 16x oversample tick (651 = 9600 baud at 100 MHz); legal range >=2.
REQ-002 Parameter DATA_BITS, 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, 0, 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.
REQ-005 sysclk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 UART_RX  in  1  asynchronous serial line, idle high.
REQ-008 RX_ACK  in  1  consumer read strobe; clears RX_VALID and RX_OVERRUN.
REQ-009 RX_STATUS  out  1  one-sysclk pulse per committed frame.
REQ-010 RX_VALID  out  1  unread frame held in RX_DATA.
REQ-011 RX_DATA  out  DATA_BITS  last committed data word, LSB = first received bit.
REQ-012 RX_FERR  out  1  framing error flag for the frame in RX_DATA.
REQ-013 RX_PERR  out  1  parity error flag for the frame in RX_DATA; always 0 when PARITY=0.
REQ-014 RX_OVERRUN  out  1  sticky: a frame was committed while RX_VALID=1 and no RX_ACK was given.

Function
REQ-015 UART_RX SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value only.
REQ-016 Internal tick divider SHALL pulse once every DIVISOR sysclk cycles, restarting at count 0 on entry to START.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-018 IDLE -> START on a synchronised high-to-low transition; the tick counter (0..15) clears on entry.
REQ-019 Every bit SHALL be resolved by a 2-of-3 majority of samples taken at ticks 7, 8 and 9 of that bit; the bit period ends at tick 15.
REQ-020 START: majority 1 -> IDLE (glitch rejected, no outputs change); majority 0 -> DATA at end of bit.
REQ-021 DATA: shift DATA_BITS bits LSB-first -> PARITY or STOP.
REQ-022 PARITY: PERR = received bit != (XOR of data) for even, or != NOT(XOR of data) for odd.
REQ-023 STOP: each of STOP_BITS bits SHALL be sampled; any majority 0 sets the frame's FERR.
REQ-024 Commit at tick 9 of the last stop bit, then -> IDLE immediately, so back-to-back frames with a 1-stop-bit gap are accepted.
REQ-025 On commit: RX_DATA, RX_FERR and RX_PERR load the frame values; RX_STATUS=1 for exactly that cycle; RX_VALID=1.
REQ-026 Frames with FERR or PERR SHALL still be committed with their flags.
REQ-027 Commit while RX_VALID=1 without RX_ACK that cycle sets RX_OVERRUN; RX_DATA is overwritten with the new frame.
REQ-028 RX_ACK with no commit that cycle clears RX_VALID and RX_OVERRUN next edge; RX_ACK in the commit cycle: commit wins, RX_VALID stays 1, RX_OVERRUN is not set.
REQ-029 A line held low through STOP (break) SHALL commit with RX_FERR=1 and SHALL NOT start a new frame until the line returns high and falls again.

Reset
REQ-030 While reset=0: state IDLE; divider, tick counter and shift register cleared; synchroniser flops = 1.
REQ-031 While reset=0: RX_STATUS, RX_VALID, RX_DATA, RX_FERR, RX_PERR and RX_OVERRUN SHALL all be 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; no commit may occur for it after release.

Verification
REQ-033 Defaults, 100 MHz sysclk, 104166 ns bits: frames 0x7F, 0x01, 0x02, 0x03 back-to-back, RX_ACK after each -> four RX_STATUS pulses with matching RX_DATA and all error flags 0.
REQ-034 UART_RX low for 3 ticks, then high -> no RX_STATUS pulse, RX_VALID stays 0, and the next valid frame 0x55 is received correctly.
REQ-035 PARITY=2, frame 0x03 with parity bit 1 -> RX_DATA=0x03, RX_PERR=1; the same frame with parity bit 0 -> RX_PERR=0.
REQ-036 Frame 0xA5 with stop bit 0 -> RX_DATA=0xA5, RX_FERR=1; STOP_BITS=2 with the second stop bit 0 -> RX_FERR=1.
REQ-037 Frames 0x11 then 0x22 with no RX_ACK -> RX_OVERRUN=1, RX_DATA=0x22; RX_ACK -> RX_VALID=0 and RX_OVERRUN=0 next cycle.
REQ-038 reset pulsed low during data bit 4 -> all outputs 0 with no RX_STATUS pulse afterwards; the following frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_receiver_cfg.sv
// UART receiver with a 16x oversampled bit clock, 2-of-3 mid-bit majority voting,
// optional parity, 1 or 2 stop bits, and a single-entry holding register with overrun.
module uart_receiver_cfg #(
  parameter int DIVISOR   = 651,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  input  logic                 RX_ACK,
  output logic                 RX_STATUS,
  output logic                 RX_VALID,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_FERR,
  output logic                 RX_PERR,
  output logic                 RX_OVERRUN
);

  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [DW-1:0]        div_q, div_d;
  logic [3:0]           tck_q, tck_d;
  logic [3:0]           bit_q, bit_d;
  logic                 s7_q, s7_d, s8_q, s8_d;
  logic [DATA_BITS-1:0] shf_q, shf_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic                 status_q, status_d, valid_q, valid_d, ovr_q, ovr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rferr_q, rferr_d, rperr_q, rperr_d;
  logic                 rx, tick, mid, last, maj, commit, fe_now, odd;

  assign rx     = sync2_q;
  assign tick   = (div_q == DW'(DIVISOR - 1));
  assign mid    = tick && (tck_q == 4'd9);
  assign last   = tick && (tck_q == 4'd15);
  assign maj    = (s7_q & s8_q) | (s7_q & rx) | (s8_q & rx);
  assign fe_now = ferr_q | ~maj;
  assign odd    = (PARITY == 1);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    tck_d   = tick ? tck_q + 4'd1 : tck_q;
    bit_d   = bit_q;
    s7_d    = (tick && tck_q == 4'd7) ? rx : s7_q;
    s8_d    = (tick && tck_q == 4'd8) ? rx : s8_q;
    shf_d   = shf_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Divider and tick counter are held at zero so START begins phase-aligned to the edge.
        div_d = '0;
        tck_d = '0;
        if (prev_q && !rx) begin
          state_d = S_START;
          bit_d   = '0;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (mid && maj)  state_d = S_IDLE;
        else if (last)   state_d = S_DATA;
      end
      S_DATA: begin
        if (mid) shf_d = {maj, shf_q[DATA_BITS-1:1]};
        if (last) begin
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY == 0) ? S_STOP : S_PAR;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (mid)  perr_d = (maj != ((^shf_q) ^ odd));
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        if (mid) begin
          ferr_d = fe_now;
          // Committing mid-bit leaves half a bit of margin for a back-to-back start edge.
          if (bit_q == 4'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end
        end
        if (last) bit_d = bit_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    status_d = commit;
    valid_d  = commit ? 1'b1 : (RX_ACK ? 1'b0 : valid_q);
    ovr_d    = RX_ACK ? 1'b0 : (ovr_q | (commit & valid_q));
    data_d   = commit ? shf_q  : data_q;
    rferr_d  = commit ? fe_now : rferr_q;
    rperr_d  = commit ? perr_q : rperr_q;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      div_q    <= '0;
      tck_q    <= '0;
      bit_q    <= '0;
      s7_q     <= 1'b1;
      s8_q     <= 1'b1;
      shf_q    <= '0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      status_q <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      data_q   <= '0;
      rferr_q  <= 1'b0;
      rperr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= UART_RX;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      div_q    <= div_d;
      tck_q    <= tck_d;
      bit_q    <= bit_d;
      s7_q     <= s7_d;
      s8_q     <= s8_d;
      shf_q    <= shf_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      status_q <= status_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      data_q   <= data_d;
      rferr_q  <= rferr_d;
      rperr_q  <= rperr_d;
    end
  end

  assign RX_STATUS  = status_q;
  assign RX_VALID   = valid_q;
  assign RX_DATA    = data_q;
  assign RX_FERR    = rferr_q;
  assign RX_PERR    = rperr_q;
  assign RX_OVERRUN = ovr_q;

endmodule
